// File: rtl/instr_exec_ctrl.sv
// Command execution controller: decodes HPS PIO command words and sequences
// single-pixel reads and writes against a fixed-latency pixel memory.
module instr_exec_ctrl #(
    parameter int ADDR_MAX = 76800,
    parameter int RD_LAT   = 2
) (
    input  logic        clk_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [28:0] instruct,
    input  logic        mem_sel,
    output logic [3:0]  flags,
    output logic [7:0]  data_out,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_rd,
    output logic        mem_bank,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        READ_WAIT = 3'd2,
        WRITE     = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [2:0]  OP_NOP   = 3'b000;
    localparam logic [2:0]  OP_READ  = 3'b001;
    localparam logic [2:0]  OP_WRITE = 3'b010;
    localparam logic [2:0]  OP_CLEAR = 3'b011;
    localparam logic [31:0] ADDR_LIM = 32'(ADDR_MAX);
    localparam logic [7:0]  LAT_LAST = 8'(RD_LAT);

    state_t      state_r;
    logic        en_r;
    logic        armed_r;
    logic        done_wait_r;
    logic [2:0]  opcode_r;
    logic [7:0]  cnt_r;
    logic        start_s;
    logic        addr_ok_s;
    logic        unused_rsv_s;

    // armed_r blocks a start from an enable level that was already high at reset release
    assign start_s      = enable & ~en_r & armed_r;
    assign addr_ok_s    = ({15'd0, mem_addr} < ADDR_LIM);
    assign unused_rsv_s = instruct[28];

    // Main sequencer: state, handshake flags, memory strobes and read-back data
    always_ff @(posedge clk_clk) begin
        if (reset) begin
            state_r     <= IDLE;
            en_r        <= 1'b0;
            armed_r     <= 1'b0;
            done_wait_r <= 1'b0;
            opcode_r    <= 3'd0;
            cnt_r       <= 8'd0;
            flags       <= 4'b1000;
            data_out    <= 8'd0;
            mem_addr    <= 17'd0;
            mem_wdata   <= 8'd0;
            mem_we      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_bank    <= 1'b0;
        end else begin
            en_r    <= enable;
            armed_r <= armed_r | ~enable;
            mem_we  <= 1'b0;
            mem_rd  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        opcode_r  <= instruct[2:0];
                        mem_addr  <= instruct[19:3];
                        mem_wdata <= instruct[27:20];
                        mem_bank  <= mem_sel;
                        flags     <= 4'b0100;
                        state_r   <= DECODE;
                    end
                end
                DECODE: begin
                    // Non-memory paths spend one settle cycle in DONE so every
                    // non-read command completes with the same latency as WRITE.
                    done_wait_r <= 1'b1;
                    state_r     <= DONE;
                    flags       <= 4'b0000;
                    case (opcode_r)
                        OP_NOP: begin
                            flags <= 4'b0000;
                        end
                        OP_READ: begin
                            if (addr_ok_s) begin
                                mem_rd      <= 1'b1;
                                cnt_r       <= 8'd0;
                                done_wait_r <= 1'b0;
                                flags       <= 4'b0100;
                                state_r     <= READ_WAIT;
                            end else begin
                                flags <= 4'b0010;
                            end
                        end
                        OP_WRITE: begin
                            if (addr_ok_s) begin
                                mem_we      <= 1'b1;
                                done_wait_r <= 1'b0;
                                flags       <= 4'b0100;
                                state_r     <= WRITE;
                            end else begin
                                flags <= 4'b0010;
                            end
                        end
                        OP_CLEAR: begin
                            data_out <= 8'd0;
                        end
                        default: begin
                            flags <= 4'b0010;
                        end
                    endcase
                end
                READ_WAIT: begin
                    if (cnt_r == LAT_LAST) begin
                        data_out <= mem_rdata;
                        flags    <= 4'b0001;
                        state_r  <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                WRITE: begin
                    flags   <= 4'b0001;
                    state_r <= DONE;
                end
                DONE: begin
                    if (done_wait_r) begin
                        done_wait_r <= 1'b0;
                        flags[0]    <= 1'b1;
                    end else if (!enable) begin
                        flags   <= {1'b1, 1'b0, flags[1], 1'b0};
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    flags   <= 4'b1000;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_ctrl.sv
// Self-checking bench for instr_exec_ctrl: vector table through a scoreboard
// queue, plus hand sequences for reset release, handshake and mid-read reset.
module tb_instr_exec_ctrl;

    localparam int RD_LAT   = 2;
    localparam int ADDR_MAX = 76800;

    logic        clk_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [28:0] instruct;
    logic        mem_sel;
    logic [3:0]  flags;
    logic [7:0]  data_out;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_rd;
    logic        mem_bank;
    logic [7:0]  mem_rdata;

    instr_exec_ctrl #(.ADDR_MAX(ADDR_MAX), .RD_LAT(RD_LAT)) dut (
        .clk_clk  (clk_clk),
        .reset    (reset),
        .enable   (enable),
        .instruct (instruct),
        .mem_sel  (mem_sel),
        .flags    (flags),
        .data_out (data_out),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_bank (mem_bank),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [2:0]  op;
        logic [16:0] addr;
        logic [7:0]  wd;
        logic        sel;
        logic        rsv;
        logic [7:0]  rdv;
        logic [3:0]  ef;
        logic [7:0]  ed;
        int          ewe;
        int          erd;
        int          elat;
    } vec_t;

    vec_t        vecs[10];
    vec_t        sb_q[$];
    vec_t        v;
    vec_t        exp_v;
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          rd_cnt = 0;
    int          rd_cd;
    int          lat;
    logic [7:0]  rd_value = 8'h00;
    logic [16:0] we_addr;
    logic [16:0] rd_addr;
    logic [7:0]  we_data;
    logic        we_bank;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model and strobe monitor; read data is valid only RD_LAT cycles after mem_rd
    initial begin
        rd_cd     = -1;
        mem_rdata = 8'hEE;
        forever begin
            @(posedge clk_clk);
            #1;
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_data = mem_wdata;
                we_bank = mem_bank;
            end
            if (mem_rd) begin
                rd_cnt++;
                rd_addr = mem_addr;
            end
            if (rd_cd > 0) rd_cd--;
            if (mem_rd) rd_cd = RD_LAT;
            if (rd_cd == 0) begin
                mem_rdata = rd_value;
                rd_cd     = -1;
            end else begin
                mem_rdata = 8'hEE;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [16:0] addr, input logic [7:0] wd,
                         input logic sel, input logic rsv);
        @(negedge clk_clk);
        instruct = {rsv, wd, addr, op};
        mem_sel  = sel;
        enable   = 1'b1;
        we_cnt   = 0;
        rd_cnt   = 0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_clk);
            if (flags[0]) begin
                cycles = c;
                break;
            end
        end
    endtask

    initial begin
        vecs[0] = '{3'b010, 17'd100,   8'hA5, 1'b1, 1'b0, 8'h00, 4'b0001, 8'h00, 1, 0, 3};
        vecs[1] = '{3'b001, 17'd100,   8'h00, 1'b0, 1'b0, 8'h3C, 4'b0001, 8'h3C, 0, 1, 5};
        vecs[2] = '{3'b001, 17'd76800, 8'h00, 1'b0, 1'b0, 8'h99, 4'b0011, 8'h3C, 0, 0, 3};
        vecs[3] = '{3'b101, 17'd5,     8'h00, 1'b0, 1'b0, 8'h00, 4'b0011, 8'h3C, 0, 0, 3};
        vecs[4] = '{3'b000, 17'd7,     8'h11, 1'b0, 1'b0, 8'h00, 4'b0001, 8'h3C, 0, 0, 3};
        vecs[5] = '{3'b001, 17'd76799, 8'h00, 1'b1, 1'b0, 8'h5A, 4'b0001, 8'h5A, 0, 1, 5};
        vecs[6] = '{3'b011, 17'd9,     8'h00, 1'b0, 1'b0, 8'h00, 4'b0001, 8'h00, 0, 0, 3};
        vecs[7] = '{3'b010, 17'd76800, 8'h42, 1'b1, 1'b0, 8'h00, 4'b0011, 8'h00, 0, 0, 3};
        vecs[8] = '{3'b111, 17'd1,     8'h00, 1'b0, 1'b0, 8'h00, 4'b0011, 8'h00, 0, 0, 3};
        vecs[9] = '{3'b010, 17'd0,     8'h01, 1'b0, 1'b1, 8'h00, 4'b0001, 8'h00, 1, 0, 3};

        // Reset state, with enable held high across reset release
        reset    = 1'b1;
        enable   = 1'b1;
        mem_sel  = 1'b1;
        instruct = {1'b0, 8'hA5, 17'd100, 3'b010};
        repeat (3) @(negedge clk_clk);
        chk("rst_flags", 32'(flags), 32'(4'b1000));
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_strobes", 32'({mem_we, mem_rd, mem_bank}), 32'd0);
        reset  = 1'b0;
        we_cnt = 0;
        rd_cnt = 0;
        repeat (4) @(negedge clk_clk);
        chk("rel_no_start_flags", 32'(flags), 32'(4'b1000));
        chk("rel_no_start_we", 32'(we_cnt), 32'd0);
        enable = 1'b0;
        @(negedge clk_clk);

        // Table-driven commands through the scoreboard
        for (int i = 0; i < 10; i++) begin
            v        = vecs[i];
            rd_value = v.rdv;
            issue(v.op, v.addr, v.wd, v.sel, v.rsv);
            sb_q.push_back(v);
            wait_done(lat);
            exp_v = sb_q.pop_front();
            chk($sformatf("v%0d_flags", i), 32'(flags), 32'(exp_v.ef));
            chk($sformatf("v%0d_data_out", i), 32'(data_out), 32'(exp_v.ed));
            chk($sformatf("v%0d_we_cnt", i), 32'(we_cnt), 32'(exp_v.ewe));
            chk($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt), 32'(exp_v.erd));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_v.elat));
            if (exp_v.ewe > 0) begin
                chk($sformatf("v%0d_we_addr", i), 32'(we_addr), 32'(exp_v.addr));
                chk($sformatf("v%0d_we_data", i), 32'(we_data), 32'(exp_v.wd));
                chk($sformatf("v%0d_we_bank", i), 32'(we_bank), 32'(exp_v.sel));
            end
            if (exp_v.erd > 0) begin
                chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(exp_v.addr));
            end
            enable = 1'b0;
            @(negedge clk_clk);
            chk($sformatf("v%0d_ready", i), 32'(flags), 32'({1'b1, 1'b0, exp_v.ef[1], 1'b0}));
        end

        // Handshake: edge during busy ignored, enable held high keeps DONE
        rd_value = 8'h66;
        issue(3'b001, 17'd200, 8'h00, 1'b0, 1'b0);
        @(negedge clk_clk);
        enable = 1'b0;
        @(negedge clk_clk);
        enable = 1'b1;
        repeat (3) @(negedge clk_clk);
        chk("hs_done_flags", 32'(flags), 32'(4'b0001));
        chk("hs_data_out", 32'(data_out), 32'h66);
        repeat (3) @(negedge clk_clk);
        chk("hs_hold_flags", 32'(flags), 32'(4'b0001));
        chk("hs_hold_rd_cnt", 32'(rd_cnt), 32'd1);
        enable = 1'b0;
        @(negedge clk_clk);
        chk("hs_ready", 32'(flags), 32'(4'b1000));
        repeat (3) @(negedge clk_clk);
        chk("hs_no_queue_flags", 32'(flags), 32'(4'b1000));
        chk("hs_no_queue_rd_cnt", 32'(rd_cnt), 32'd1);

        // Reset during READ_WAIT; the late read return must be discarded
        rd_value = 8'h77;
        issue(3'b001, 17'd300, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk_clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk_clk);
        chk("rw_rst_flags", 32'(flags), 32'(4'b1000));
        chk("rw_rst_data_out", 32'(data_out), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk_clk);
        chk("rw_after_flags", 32'(flags), 32'(4'b1000));
        chk("rw_after_data_out", 32'(data_out), 32'd0);
        chk("rw_after_rd_cnt", 32'(rd_cnt), 32'd1);
        chk("rw_after_we_cnt", 32'(we_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
